// File: rtl/main_memory_responder.sv
// Pipelined main-memory responder for the cache-fill bus: one word read or write
// per cycle, reads answered a fixed LATENCY cycles later with the word's address echoed.
module main_memory_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4,
    parameter int WORDS   = 2 ** (ADDR_W - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_valid,
    output logic              busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0] mem [WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              wr_en;
    logic              addr_lsb_unused;
    stage_t            req;
    stage_t            last_in;
    stage_t            out_q;
    logic              pre_busy;

    // Byte address bit 0 selects nothing; upper bits beyond the array depth wrap.
    assign word_idx        = addr[IDX_W:1];
    assign addr_lsb_unused = addr[0];
    assign wr_en           = rst_n & enable & wr;

    // Read data is captured from the array in the issue cycle, so a later write
    // to the same word cannot disturb a read already in flight.
    always_comb begin
        req.valid = enable & ~wr;
        req.addr  = {addr[ADDR_W-1:1], 1'b0};
        req.data  = mem[word_idx];
    end

    // NOTE: the storage array has no reset; its contents must survive rst_n and a
    // reset term would also stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_idx] <= data_in;
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign last_in  = req;
        assign pre_busy = 1'b0;
    end else begin : g_pipe
        stage_t pipe [LATENCY-1];

        // NOTE: sequential state uses non-blocking assignments so every stage
        // shifts from its neighbour's pre-edge value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= req;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign last_in = pipe[LATENCY-2];

        always_comb begin
            pre_busy = 1'b0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                pre_busy = pre_busy | pipe[i].valid;
            end
        end
    end

    // Output stage: the valid bit follows the pipe, data and address hold between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q.valid <= last_in.valid;
            if (last_in.valid) begin
                out_q.addr <= last_in.addr;
                out_q.data <= last_in.data;
            end
        end
    end

    assign data_valid = out_q.valid;
    assign data_out   = out_q.data;
    assign data_addr  = out_q.addr;
    assign busy       = out_q.valid | pre_busy;

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomised and directed bench for main_memory_responder at LATENCY 1, 4 and 6,
// checked every cycle against a per-edge request history and a word-array model.
module tb_main_memory_responder;

    localparam int MAXE = 4096;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic        dv1, bz1, dv4, bz4, dv6, bz6;
    logic [15:0] do1, da1, do4, da4, do6, da6;

    main_memory_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(do1), .data_addr(da1), .data_valid(dv1), .busy(bz1)
    );
    main_memory_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(do4), .data_addr(da4), .data_valid(dv4), .busy(bz4)
    );
    main_memory_responder #(.LATENCY(6)) u_l6 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(do6), .data_addr(da6), .data_valid(dv6), .busy(bz6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: request seen at each clock edge, plus the word array as the bench believes it.
    logic        req_v [MAXE];
    logic [15:0] req_a [MAXE];
    logic [15:0] req_d [MAXE];
    logic [15:0] mem_m [32768];
    logic [15:0] exp_do [3];
    logic [15:0] exp_da [3];
    int          edge_cnt   = 0;
    int          flush_edge = 0;
    bit          run        = 1'b0;
    int          n_checks   = 0;
    int          n_pass     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // After edge edge_cnt, a latency-L responder shows the request from edge edge_cnt-L+1.
    task automatic cmp(input string nm, input int lat, input int i, input logic v,
                       input logic b, input logic [15:0] d, input logic [15:0] a);
        int   src;
        int   s;
        logic ev;
        logic eb;
        src = edge_cnt - lat + 1;
        ev  = (src >= 1) && (src > flush_edge) && req_v[src];
        eb  = 1'b0;
        for (int j = 0; j < lat; j++) begin
            s = edge_cnt - j;
            if (s >= 1 && s > flush_edge && req_v[s]) eb = 1'b1;
        end
        if (ev) begin
            exp_do[i] = req_d[src];
            exp_da[i] = req_a[src];
        end
        check({nm, "_valid"}, 32'(v), 32'(ev));
        check({nm, "_busy"}, 32'(b), 32'(eb));
        check({nm, "_data"}, 32'(d), 32'(exp_do[i]));
        check({nm, "_addr"}, 32'(a), 32'(exp_da[i]));
    endtask

    always @(posedge clk) begin
        #1;
        if (run) begin
            cmp("l1", 1, 0, dv1, bz1, do1, da1);
            cmp("l4", 4, 1, dv4, bz4, do4, da4);
            cmp("l6", 6, 2, dv6, bz6, do6, da6);
        end
    end

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        int k;
        @(negedge clk);
        rst_n   = 1'b1;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        k = edge_cnt + 1;
        req_v[k] = 1'b0;
        if (en && !w) begin
            req_v[k] = 1'b1;
            req_a[k] = {a[15:1], 1'b0};
            req_d[k] = mem_m[a[15:1]];
        end else if (en && w) begin
            mem_m[a[15:1]] = d;
        end
        edge_cnt = k;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // One-cycle reset with a write presented that must not land.
    task automatic pulse_reset();
        int k;
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0100;
        data_in = 16'hDEAD;
        k = edge_cnt + 1;
        req_v[k]   = 1'b0;
        flush_edge = k;
        edge_cnt   = k;
        for (int i = 0; i < 3; i++) begin
            exp_do[i] = 16'h0000;
            exp_da[i] = 16'h0000;
        end
        #1;
        check("rst_async_l1_valid", 32'(dv1), 32'd0);
        check("rst_async_l4_valid", 32'(dv4), 32'd0);
        check("rst_async_l6_busy", 32'(bz6), 32'd0);
        check("rst_async_l4_busy", 32'(bz4), 32'd0);
        check("rst_async_l4_data", 32'(do4), 32'd0);
    endtask

    // Read at edge k, then pin the latency-4 response to edge k+3 by hand.
    task automatic read_lat4(input string nm, input logic [15:0] a, input logic [15:0] exp_d,
                             input logic [15:0] exp_a);
        drive(1'b1, 1'b0, a, 16'h0000);
        idle(2);
        @(posedge clk); #2;
        check({nm, "_early_valid"}, 32'(dv4), 32'd0);
        idle(1);
        @(posedge clk); #2;
        check({nm, "_valid"}, 32'(dv4), 32'd1);
        check({nm, "_data"}, 32'(do4), 32'(exp_d));
        check({nm, "_addr"}, 32'(da4), 32'(exp_a));
    endtask

    initial begin
        int r;
        for (int i = 0; i < 3; i++) begin
            exp_do[i] = 16'h0000;
            exp_da[i] = 16'h0000;
        end
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        check("reset_l4_valid", 32'(dv4), 32'd0);
        check("reset_l4_busy", 32'(bz4), 32'd0);
        check("reset_l4_data", 32'(do4), 32'd0);
        check("reset_l1_addr", 32'(da1), 32'd0);
        run = 1'b1;

        // Fill the working region so every later read has a known value.
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, 16'(2 * i), 16'($urandom));

        // Write then read back the next cycle.
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        read_lat4("beef", 16'h0010, 16'hBEEF, 16'h0010);

        // Eight back-to-back reads of preloaded words.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
        idle(1);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
        idle(8);

        // Read, then write the same word while the read is in flight, then read again.
        drive(1'b1, 1'b1, 16'h0020, 16'h1111);
        idle(1);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b1, 16'h0020, 16'h2222);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(1);
        @(posedge clk); #2;
        check("order_old_data", 32'(do4), 32'h1111);
        idle(2);
        @(posedge clk); #2;
        check("order_new_valid", 32'(dv4), 32'd1);
        check("order_new_data", 32'(do4), 32'h2222);

        // Odd byte address reads the even word.
        drive(1'b1, 1'b1, 16'h0030, 16'h5A5A);
        read_lat4("odd_addr", 16'h0031, 16'h5A5A, 16'h0030);
        idle(6);

        // Reset with reads in flight; the word at 0x0100 must keep 0xA000.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
        pulse_reset();
        idle(8);
        read_lat4("post_reset", 16'h0100, 16'hA000, 16'h0100);
        idle(6);

        // Randomised traffic, including odd addresses and occasional resets.
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) pulse_reset();
            else drive(r < 70, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 16'h01FF)),
                       16'($urandom));
        end
        idle(10);
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
